microwave_cook_ctrl: RTL and testbench

Cook-cycle controller for the microwave oven. It sequences the seconds-timer datapath: loads a cook time, prescales the clock into one-second ticks, and counts remaining time down while the magnetron is enabled. It handles door interlock, pause/resume, quick-add and an end-of-cycle beep. It sits between the keypad/door inputs and the magnetron, lamp and display drivers.

---
 rtl/microwave_cook_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microwave_cook_ctrl.sv
// -----------------------------------------------------------------------------
// microwave_cook_ctrl
//
// Cook-cycle controller for the microwave oven. Captures a cook time from the
// keypad and prescales the clock into one-second ticks. While the magnetron is
// enabled it counts the remaining seconds down. It also handles the door
// interlock, pause/resume, quick-add and the end-of-cycle beep.
//
// Parameters
//   TICKS_PER_SEC : clock cycles per cooking second (>= 2)
//   BEEP_CYC      : cycles the beep output stays high after completion (>= 1)
//   QUICK_ADD     : seconds added by start while cooking
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   door_open    in   door level, 1 = open
//   load         in   pulse: capture time_in (clamped to 99) as cook time
//   time_in      in   requested seconds, 0..127
//   start        in   pulse: start/resume, or quick-add while cooking
//   cancel       in   pulse: pause when cooking, otherwise clear to idle
//   remaining    out  seconds left, 0..99 (registered)
//   magnetron_on out  high only while cooking (registered)
//   lamp_on      out  cooking or door open
//   beep         out  high while in DONE (registered)
//   state        out  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4
// -----------------------------------------------------------------------------
module microwave_cook_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 10,
   parameter int unsigned BEEP_CYC      = 5,
   parameter int unsigned QUICK_ADD     = 30
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       door_open,
   input  logic       load,
   input  logic [6:0] time_in,
   input  logic       start,
   input  logic       cancel,
   output logic [6:0] remaining,
   output logic       magnetron_on,
   output logic       lamp_on,
   output logic       beep,
   output logic [2:0] state
);

   localparam int unsigned PW = $clog2(TICKS_PER_SEC);
   localparam int unsigned BW = $clog2(BEEP_CYC + 1);
   localparam int unsigned QA_CLAMP = (QUICK_ADD > 99) ? 99 : QUICK_ADD;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [BW-1:0] BEEP_LAST  = BW'(BEEP_CYC - 1);
   localparam logic [7:0]    QADD       = 8'(QA_CLAMP);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Keypad entries above 99 seconds are treated as 99.
   function automatic logic [6:0] clamp99(input logic [6:0] t);
      if (t > 7'd99) begin
         return 7'd99;
      end else begin
         return t;
      end
   endfunction

   // Quick-add saturates at 99; the sum is formed in 8 bits so 99+99 cannot wrap.
   function automatic logic [6:0] sat_add(input logic [6:0] r);
      logic [7:0] sum;
      sum = {1'b0, r} + QADD;
      if (sum > 8'd99) begin
         return 7'd99;
      end else begin
         return sum[6:0];
      end
   endfunction

   state_t          state_q, state_d;
   logic [6:0]      rem_q, rem_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
   logic            magnetron_q;
   logic            beep_q;

   logic            tick_s;
   logic [6:0]      time_clamped_s;
   logic [6:0]      rem_dec_s;

   // Next-state, remaining-time, prescaler and beep-counter logic.
   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      presc_d        = presc_q;
      beep_cnt_d     = '0;
      tick_s         = (presc_q == PRESC_LAST);
      time_clamped_s = clamp99(time_in);
      // The one-second decrement is applied before any quick-add on the same edge.
      if (tick_s && (rem_q != 7'd0)) begin
         rem_dec_s = rem_q - 7'd1;
      end else begin
         rem_dec_s = rem_q;
      end

      case (state_q)
         ST_IDLE: begin
            presc_d = '0;
            if (cancel) begin
               rem_d = 7'd0;
            end else if (load && (time_clamped_s != 7'd0)) begin
               state_d = ST_SET;
               rem_d   = time_clamped_s;
            end else begin
               rem_d = rem_q;
            end
         end

         ST_SET: begin
            presc_d = '0;
            if (cancel) begin
               state_d = ST_IDLE;
               rem_d   = 7'd0;
            end else if (start && !door_open) begin
               state_d = ST_COOK;
            end else if (load) begin
               if (time_clamped_s == 7'd0) begin
                  state_d = ST_IDLE;
                  rem_d   = 7'd0;
               end else begin
                  rem_d = time_clamped_s;
               end
            end else begin
               state_d = ST_SET;
            end
         end

         ST_COOK: begin
            if (cancel || door_open) begin
               // Pause holds both the prescaler and remaining time, even on a tick.
               state_d = ST_PAUSE;
            end else begin
               if (tick_s) begin
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
               if (start) begin
                  // Quick-add also rescues the edge that would otherwise hit zero.
                  rem_d = sat_add(rem_dec_s);
               end else begin
                  rem_d = rem_dec_s;
                  if (rem_dec_s == 7'd0) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_COOK;
                  end
               end
            end
         end

         ST_PAUSE: begin
            if (cancel) begin
               state_d = ST_IDLE;
               rem_d   = 7'd0;
               presc_d = '0;
            end else if (start && !door_open) begin
               state_d = ST_COOK;
            end else begin
               state_d = ST_PAUSE;
            end
         end

         ST_DONE: begin
            presc_d = '0;
            rem_d   = 7'd0;
            if (cancel || start) begin
               state_d = ST_IDLE;
            end else if (beep_cnt_q == BEEP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               beep_cnt_d = beep_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            rem_d   = 7'd0;
            presc_d = '0;
         end
      endcase
   end

   // State register and registered outputs derived from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rem_q       <= 7'd0;
         presc_q     <= '0;
         beep_cnt_q  <= '0;
         magnetron_q <= 1'b0;
         beep_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         presc_q     <= presc_d;
         beep_cnt_q  <= beep_cnt_d;
         magnetron_q <= (state_d == ST_COOK);
         beep_q      <= (state_d == ST_DONE);
      end
   end

   assign remaining    = rem_q;
   assign magnetron_on = magnetron_q;
   assign beep         = beep_q;
   assign state        = state_q;
   // The lamp follows the door immediately so the user sees inside at once.
   assign lamp_on      = magnetron_q | door_open;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// -----------------------------------------------------------------------------
// tb_microwave_cook_ctrl
//
// Self-checking bench for microwave_cook_ctrl. A behavioural model tracks the
// oven mode, seconds left, cycles elapsed in the current second and beep cycles
// left, and every cycle's outputs are compared against it. Directed scenarios
// are followed by randomized keypad/door activity.
// -----------------------------------------------------------------------------
module tb_microwave_cook_ctrl;

   localparam int TPS  = 4;
   localparam int BEEP = 3;
   localparam int QA   = 30;

   logic       clk;
   logic       rst;
   logic       door_open;
   logic       load;
   logic [6:0] time_in;
   logic       start;
   logic       cancel;
   logic [6:0] remaining;
   logic       magnetron_on;
   logic       lamp_on;
   logic       beep;
   logic [2:0] state;

   int n_checks;
   int n_fail;

   // model state: mode 0..4, seconds left, cycles into current second, beep cycles left
   int m_state;
   int m_rem;
   int m_sub;
   int m_beep_left;

   microwave_cook_ctrl #(
      .TICKS_PER_SEC(TPS),
      .BEEP_CYC     (BEEP),
      .QUICK_ADD    (QA)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .door_open   (door_open),
      .load        (load),
      .time_in     (time_in),
      .start       (start),
      .cancel      (cancel),
      .remaining   (remaining),
      .magnetron_on(magnetron_on),
      .lamp_on     (lamp_on),
      .beep        (beep),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state     = 0;
      m_rem       = 0;
      m_sub       = 0;
      m_beep_left = 0;
   endtask

   // One clock edge of oven behaviour, written from the user-level rules.
   task automatic model_step(input bit dr, input bit ld, input int t, input bit st, input bit cn);
      int tc;
      tc = (t > 99) ? 99 : t;
      case (m_state)
         0: begin
            if (cn) m_rem = 0;
            else if (ld && tc > 0) begin m_state = 1; m_rem = tc; end
         end
         1: begin
            if (cn) begin m_state = 0; m_rem = 0; end
            else if (st && !dr) begin m_state = 2; m_sub = 0; end
            else if (ld) begin
               if (tc == 0) begin m_state = 0; m_rem = 0; end
               else m_rem = tc;
            end
         end
         2: begin
            if (cn || dr) m_state = 3;
            else begin
               m_sub++;
               if (m_sub == TPS) begin m_sub = 0; m_rem--; end
               if (st) m_rem = (m_rem + QA > 99) ? 99 : m_rem + QA;
               else if (m_rem == 0) begin m_state = 4; m_beep_left = BEEP; end
            end
         end
         3: begin
            if (cn) begin m_state = 0; m_rem = 0; m_sub = 0; end
            else if (st && !dr) m_state = 2;
         end
         4: begin
            if (cn || st) m_state = 0;
            else begin
               m_beep_left--;
               if (m_beep_left == 0) m_state = 0;
            end
         end
         default: m_state = 0;
      endcase
   endtask

   task automatic compare_all();
      check_eq("state", int'(state), m_state);
      check_eq("remaining", int'(remaining), m_rem);
      check_eq("magnetron_on", int'(magnetron_on), (m_state == 2) ? 1 : 0);
      check_eq("beep", int'(beep), (m_state == 4) ? 1 : 0);
      check_eq("lamp_on", int'(lamp_on), ((m_state == 2) || door_open) ? 1 : 0);
   endtask

   // Drive one cycle of inputs, step the model on the edge, then compare.
   task automatic cycle(input bit dr, input bit ld, input logic [6:0] t, input bit st, input bit cn);
      door_open = dr;
      load      = ld;
      time_in   = t;
      start     = st;
      cancel    = cn;
      @(posedge clk);
      model_step(dr, ld, int'(t), st, cn);
      #1;
      compare_all();
      load   = 1'b0;
      start  = 1'b0;
      cancel = 1'b0;
   endtask

   initial begin
      int n;
      bit dr;
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      door_open = 1'b0;
      load      = 1'b0;
      time_in   = 7'd0;
      start     = 1'b0;
      cancel    = 1'b0;
      model_reset();

      #12;
      compare_all();
      @(negedge clk);
      rst = 1'b0;

      // Basic cook of 3 seconds: 12 cycles of COOK, then 3 cycles of beep.
      cycle(1'b0, 1'b1, 7'd3, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      n = 0;
      while (state != 3'd4 && n < 50) begin
         cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
         n++;
      end
      check_eq("cook_len", n, 12);
      n = 0;
      while (beep && n < 20) begin
         cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
         n++;
      end
      check_eq("beep_len", n, 3);
      check_eq("idle_after_beep", int'(state), 0);

      // Clamp and saturating quick-add; load 0 in IDLE is ignored.
      cycle(1'b0, 1'b1, 7'd120, 1'b0, 1'b0);
      check_eq("clamp_99", int'(remaining), 99);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      check_eq("quick_add_sat", int'(remaining), 99);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 7'd0, 1'b0, 1'b0);
      check_eq("load0_idle", int'(state), 0);

      // Door interlock pause, blocked resume, then resume to completion.
      cycle(1'b0, 1'b1, 7'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
      check_eq("door_pause_state", int'(state), 3);
      check_eq("door_pause_rem", int'(remaining), 4);
      check_eq("door_pause_mag", int'(magnetron_on), 0);
      cycle(1'b1, 1'b0, 7'd0, 1'b1, 1'b0);
      check_eq("start_door_open", int'(state), 3);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      n = 0;
      while (state != 3'd4 && n < 50) begin
         cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
         n++;
      end
      check_eq("resume_len", n, 14);
      n = 0;
      while (state != 3'd0 && n < 20) begin
         cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
         n++;
      end

      // Quick-add on the terminal edge of the last second cancels DONE.
      cycle(1'b0, 1'b1, 7'd1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      check_eq("qa_rescue_rem", int'(remaining), 30);
      check_eq("qa_rescue_state", int'(state), 2);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      check_eq("cancel_pause", int'(state), 3);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
      check_eq("cancel_idle", int'(state), 0);
      check_eq("cancel_idle_rem", int'(remaining), 0);

      // Simultaneous events follow the priority order.
      cycle(1'b0, 1'b1, 7'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b1);
      check_eq("cancel_beats_start", int'(state), 0);
      cycle(1'b0, 1'b1, 7'd5, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 7'd0, 1'b1, 1'b0);
      check_eq("door_beats_start", int'(state), 3);
      check_eq("door_beats_start_rem", int'(remaining), 5);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a cook.
      cycle(1'b0, 1'b1, 7'd7, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
      check_eq("pre_reset_rem", int'(remaining), 7);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_eq("async_rst_state", int'(state), 0);
      check_eq("async_rst_rem", int'(remaining), 0);
      check_eq("async_rst_mag", int'(magnetron_on), 0);
      check_eq("async_rst_beep", int'(beep), 0);
      @(negedge clk);
      rst = 1'b0;

      // Randomized keypad and door activity against the model.
      dr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         bit ld, st, cn;
         logic [6:0] t;
         if ($urandom_range(0, 39) == 0) dr = ~dr;
         ld = ($urandom_range(0, 14) == 0);
         st = ($urandom_range(0, 24) == 0);
         cn = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 1) == 0) t = 7'($urandom_range(0, 12));
         else t = 7'($urandom_range(0, 127));
         cycle(dr, ld, t, st, cn);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
